// File: rtl/mips_bus_pkg.sv
// Shared types and byte-lane helpers for the MIPS-to-Avalon load/store unit.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_e;

    // A request is legal when its size is defined and the address is naturally aligned.
    function automatic logic req_legal(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lo[0];
            SZ_WORD: ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Avalon byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-justified store data replicated across every lane it could land in.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wd[7:0]}};
            SZ_HALF: d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Pull the addressed lane out of a bus word and sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                 input logic        sgn,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] rd);
        logic [31:0] sh;
        logic [15:0] h;
        logic [31:0] r;
        sh = rd >> {lo, 3'b000};
        h  = lo[1] ? rd[31:16] : rd[15:0];
        case (size)
            SZ_BYTE: r = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            SZ_WORD: r = rd;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_bus_arbiter.sv
// Grant selection across requester ports: fixed priority or round-robin.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int NPORT    = 2,
    parameter int ARB_MODE = 0,
    localparam int IW      = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NPORT-1:0] req_valid_i,
    input  logic             accept_i,
    output logic [NPORT-1:0] grant_o,
    output logic [IW-1:0]    gidx_o,
    output logic             any_o
);

    logic [IW-1:0] last_q, last_d;

    // Choose the winning port; round-robin searches upward from the last grant.
    always_comb begin
        logic [IW-1:0] idx;
        gidx_o = '0;
        any_o  = 1'b0;
        idx    = '0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < NPORT; i++) begin
                if (req_valid_i[i]) begin
                    gidx_o = IW'(i);
                    any_o  = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NPORT; k++) begin
                idx = IW'((int'(last_q) + k) % NPORT);
                if (!any_o && req_valid_i[idx]) begin
                    gidx_o = idx;
                    any_o  = 1'b1;
                end
            end
        end
        grant_o = any_o ? (NPORT'(1) << gidx_o) : '0;
        last_d  = accept_i ? gidx_o : last_q;
    end

    // Remember who was served last so round-robin can rotate past it.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= IW'(NPORT - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mips_bus_lsu.sv
// Multi-port load/store unit bridging MIPS-style requests onto one Avalon-MM master.
module mips_bus_lsu
    import mips_bus_pkg::*;
#(
    parameter int NPORT    = 2,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NPORT-1:0]    req_valid,
    output logic [NPORT-1:0]    req_ready,
    input  logic [NPORT*32-1:0] req_addr,
    input  logic [NPORT-1:0]    req_write,
    input  logic [NPORT*2-1:0]  req_size,
    input  logic [NPORT-1:0]    req_signed,
    input  logic [NPORT*32-1:0] req_wdata,
    output logic [NPORT-1:0]    rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic [31:0]         address,
    output logic                read,
    output logic                write,
    input  logic                waitrequest,
    output logic [31:0]         writedata,
    output logic [3:0]          byteenable,
    input  logic [31:0]         readdata
);

    localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] STALL_LIMIT = CW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [IW-1:0] port_q, port_d;
    logic [31:0]   addr_q, addr_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [NPORT-1:0] grant;
    logic [IW-1:0]    gidx;
    logic             anyValid;
    logic             accept;
    logic [31:0]      selAddr;
    logic [31:0]      selWdata;
    logic             selWrite;
    logic             selSigned;
    logic [1:0]       selSize;

    assign accept    = (state_q == IDLE) && anyValid && !reset;
    assign req_ready = accept ? grant : '0;

    assign selAddr   = req_addr[int'(gidx)*32 +: 32];
    assign selWdata  = req_wdata[int'(gidx)*32 +: 32];
    assign selSize   = req_size[int'(gidx)*2 +: 2];
    assign selWrite  = req_write[gidx];
    assign selSigned = req_signed[gidx];

    mips_bus_arbiter #(
        .NPORT    (NPORT),
        .ARB_MODE (ARB_MODE)
    ) u_arbiter (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .accept_i    (accept),
        .grant_o     (grant),
        .gidx_o      (gidx),
        .any_o       (anyValid)
    );

    // Sequence each request: capture, run the bus cycle (or skip it if illegal), respond.
    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        addr_d   = addr_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        stall_d  = stall_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    port_d   = gidx;
                    addr_d   = selAddr;
                    write_d  = selWrite;
                    size_d   = selSize;
                    signed_d = selSigned;
                    wdata_d  = selWdata;
                    stall_d  = '0;
                    if (req_legal(selSize, selAddr[1:0])) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end
                end
            end
            ISSUE: begin
                if (!waitrequest) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = write_q ? 32'h0
                                      : load_extract(size_q, signed_q, addr_q[1:0], readdata);
                end else if (TIMEOUT != 0 && stall_q == STALL_LIMIT) begin
                    // A completed transfer takes priority; only a still-stalled bus times out.
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transaction registers; reset abandons any transfer in flight without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            port_q   <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            stall_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            stall_q  <= stall_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Bus and response outputs decode purely from registered state, so they hold steady under stall.
    always_comb begin
        address    = 32'h0;
        read       = 1'b0;
        write      = 1'b0;
        byteenable = 4'b0000;
        writedata  = 32'h0;
        rsp_valid  = '0;
        rsp_rdata  = 32'h0;
        rsp_err    = 1'b0;
        busy       = (state_q != IDLE);
        if (state_q == ISSUE) begin
            address    = {addr_q[31:2], 2'b00};
            read       = ~write_q;
            write      = write_q;
            byteenable = lane_be(size_q, addr_q[1:0]);
            writedata  = lane_wdata(size_q, wdata_q);
        end
        if (state_q == RESP) begin
            rsp_valid = NPORT'(1) << port_q;
            rsp_rdata = rdata_q;
            rsp_err   = err_q;
        end
    end

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Directed testbench for mips_bus_lsu: vector table plus multi-cycle corner sequences.
module tb_mips_bus_lsu;

    localparam int NPORT = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NPORT-1:0]   req_valid;
    logic [NPORT-1:0]   req_ready;
    logic [NPORT*32-1:0] req_addr;
    logic [NPORT-1:0]   req_write;
    logic [NPORT*2-1:0] req_size;
    logic [NPORT-1:0]   req_signed;
    logic [NPORT*32-1:0] req_wdata;
    logic [NPORT-1:0]   rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic               busy;
    logic [31:0]        address;
    logic               read;
    logic               write;
    logic               waitrequest;
    logic [31:0]        writedata;
    logic [3:0]         byteenable;
    logic [31:0]        readdata;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] rdIn;
        logic        legal;
        logic [31:0] expAddress;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expRdata;
        string       name;
    } vec_t;

    vec_t vecs [14];

    mips_bus_lsu #(
        .NPORT    (NPORT),
        .ARB_MODE (1),
        .TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .address     (address),
        .read        (read),
        .write       (write),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic driveReq(input int p, input logic [31:0] a, input logic w, input logic [1:0] s,
                            input logic sg, input logic [31:0] wd);
        req_addr[p*32 +: 32] = a;
        req_write[p]         = w;
        req_size[p*2 +: 2]   = s;
        req_signed[p]        = sg;
        req_wdata[p*32 +: 32] = wd;
        req_valid[p]         = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [1:0] expPort;
        expPort = 2'b01 << v.port;
        tick();
        driveReq(v.port, v.addr, v.wr, v.size, v.sgn, v.wdata);
        readdata    = v.rdIn;
        waitrequest = 1'b0;
        sample();
        checkOutput({v.name, ".ready"}, req_ready, expPort);
        tick();
        req_valid[v.port] = 1'b0;
        sample();
        if (v.legal) begin
            checkOutput({v.name, ".address"}, address, v.expAddress);
            checkOutput({v.name, ".be"}, byteenable, v.expBe);
            checkOutput({v.name, ".read"}, read, !v.wr);
            checkOutput({v.name, ".write"}, write, v.wr);
            if (v.wr) checkOutput({v.name, ".wdata"}, writedata, v.expWdata);
            checkOutput({v.name, ".early_rsp"}, rsp_valid, 2'b00);
            tick();
            sample();
        end else begin
            checkOutput({v.name, ".no_read"}, read, 1'b0);
            checkOutput({v.name, ".no_write"}, write, 1'b0);
        end
        checkOutput({v.name, ".rsp_valid"}, rsp_valid, expPort);
        checkOutput({v.name, ".rsp_err"}, rsp_err, !v.legal);
        checkOutput({v.name, ".rsp_rdata"}, rsp_rdata, v.expRdata);
        checkOutput({v.name, ".bus_idle"}, read | write, 1'b0);
        tick();
        sample();
        checkOutput({v.name, ".back_idle"}, busy, 1'b0);
        checkOutput({v.name, ".single_rsp"}, rsp_valid, 2'b00);
    endtask

    initial begin
        logic [1:0] grants [4];
        logic [1:0] expGrants [4];
        int         nGrant;
        int         cnt;

        //            port addr          wr    size   sgn   wdata         rdIn          legal expAddr       be       expWdata      expRdata      name
        vecs[0]  = '{1, 32'h0000_1003, 1'b0, 2'b00, 1'b1, 32'h0,        32'h80FF_FF00, 1'b1, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80, "ldb_s_l3"};
        vecs[1]  = '{0, 32'h0000_1003, 1'b0, 2'b00, 1'b0, 32'h0,        32'h80FF_FF00, 1'b1, 32'h0000_1000, 4'b1000, 32'h0,        32'h0000_0080, "ldb_u_l3"};
        vecs[2]  = '{1, 32'h0000_2002, 1'b0, 2'b01, 1'b1, 32'h0,        32'h8001_7FFF, 1'b1, 32'h0000_2000, 4'b1100, 32'h0,        32'hFFFF_8001, "ldh_s_hi"};
        vecs[3]  = '{1, 32'h0000_2000, 1'b0, 2'b01, 1'b0, 32'h0,        32'h8001_FFFE, 1'b1, 32'h0000_2000, 4'b0011, 32'h0,        32'h0000_FFFE, "ldh_u_lo"};
        vecs[4]  = '{0, 32'h0000_3004, 1'b0, 2'b10, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b1, 32'h0000_3004, 4'b1111, 32'h0,        32'hDEAD_BEEF, "ldw"};
        vecs[5]  = '{1, 32'h0000_4001, 1'b1, 2'b00, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 32'h0000_4000, 4'b0010, 32'h7878_7878, 32'h0,       "stb_l1"};
        vecs[6]  = '{0, 32'h0000_5008, 1'b1, 2'b10, 1'b0, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b1, 32'h0000_5008, 4'b1111, 32'hCAFE_F00D, 32'h0,       "stw"};
        vecs[7]  = '{1, 32'h0000_3001, 1'b0, 2'b10, 1'b0, 32'h0,        32'h1234_5678, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        "ldw_mis"};
        vecs[8]  = '{0, 32'h0000_2003, 1'b0, 2'b01, 1'b1, 32'h0,        32'h1234_5678, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        "ldh_mis"};
        vecs[9]  = '{1, 32'h0000_0100, 1'b0, 2'b11, 1'b0, 32'h0,        32'h1234_5678, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        "rsvd"};
        vecs[10] = '{0, 32'h0000_6001, 1'b0, 2'b00, 1'b1, 32'h0,        32'h0000_7F00, 1'b1, 32'h0000_6000, 4'b0010, 32'h0,        32'h0000_007F, "ldb_s_l1"};
        vecs[11] = '{1, 32'h0000_6000, 1'b0, 2'b01, 1'b1, 32'h0,        32'h1234_8000, 1'b1, 32'h0000_6000, 4'b0011, 32'h0,        32'hFFFF_8000, "ldh_s_lo"};
        vecs[12] = '{0, 32'h0000_7008, 1'b1, 2'b01, 1'b0, 32'hAAAA_1234, 32'hFFFF_FFFF, 1'b1, 32'h0000_7008, 4'b0011, 32'h1234_1234, 32'h0,       "sth_lo"};
        vecs[13] = '{1, 32'h0000_6002, 1'b0, 2'b00, 1'b0, 32'h0,        32'h00AB_0000, 1'b1, 32'h0000_6000, 4'b0100, 32'h0,        32'h0000_00AB, "ldb_u_l2"};

        reset       = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_write   = '0;
        req_size    = '0;
        req_signed  = '0;
        req_wdata   = '0;
        waitrequest = 1'b0;
        readdata    = 32'h0;

        // Reset state, with requests pending that must not be accepted.
        tick();
        driveReq(0, 32'h10, 1'b0, 2'b10, 1'b0, 32'h0);
        driveReq(1, 32'h20, 1'b0, 2'b10, 1'b0, 32'h0);
        sample();
        checkOutput("rst.ready", req_ready, 2'b00);
        checkOutput("rst.rsp_valid", rsp_valid, 2'b00);
        checkOutput("rst.rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst.rsp_err", rsp_err, 1'b0);
        checkOutput("rst.busy", busy, 1'b0);
        checkOutput("rst.rw", {read, write}, 2'b00);
        checkOutput("rst.be", byteenable, 4'b0000);
        checkOutput("rst.address", address, 32'h0);
        checkOutput("rst.writedata", writedata, 32'h0);
        tick();
        req_valid = '0;
        reset     = 1'b0;
        sample();
        checkOutput("rst.released_idle", busy, 1'b0);

        // Single-transaction vectors.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
        end

        // Half store with three stall cycles while port 0 waits behind it.
        tick();
        driveReq(1, 32'h0000_2002, 1'b1, 2'b01, 1'b0, 32'h0000_BEEF);
        readdata = 32'hFFFF_FFFF;
        sample();
        checkOutput("sth_wait.ready", req_ready, 2'b10);
        tick();
        req_valid[1] = 1'b0;
        driveReq(0, 32'h0000_8000, 1'b0, 2'b10, 1'b0, 32'h0);
        readdata = 32'h1122_3344;
        for (int i = 0; i < 4; i++) begin
            waitrequest = (i < 3);
            sample();
            checkOutput("sth_wait.wdata", writedata, 32'hBEEF_BEEF);
            checkOutput("sth_wait.be", byteenable, 4'b1100);
            checkOutput("sth_wait.rw", {read, write}, 2'b01);
            checkOutput("sth_wait.address", address, 32'h0000_2000);
            checkOutput("sth_wait.ready_blocked", req_ready, 2'b00);
            checkOutput("sth_wait.no_rsp", rsp_valid, 2'b00);
            tick();
        end
        sample();
        checkOutput("sth_wait.rsp_valid", rsp_valid, 2'b10);
        checkOutput("sth_wait.rsp_err", rsp_err, 1'b0);
        checkOutput("sth_wait.rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("sth_wait.resp_ready_blocked", req_ready, 2'b00);
        tick();
        sample();
        checkOutput("queued.ready", req_ready, 2'b01);
        tick();
        req_valid[0] = 1'b0;
        sample();
        checkOutput("queued.read", read, 1'b1);
        checkOutput("queued.address", address, 32'h0000_8000);
        tick();
        sample();
        checkOutput("queued.rsp_valid", rsp_valid, 2'b01);
        checkOutput("queued.rsp_rdata", rsp_rdata, 32'h1122_3344);
        tick();
        sample();
        checkOutput("queued.idle", busy, 1'b0);

        // Round-robin with both ports requesting continuously from a fresh reset.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        driveReq(0, 32'h0000_0010, 1'b0, 2'b00, 1'b0, 32'h0);
        driveReq(1, 32'h0000_0021, 1'b0, 2'b00, 1'b0, 32'h0);
        readdata  = 32'h0;
        expGrants = '{2'b01, 2'b10, 2'b01, 2'b10};
        nGrant    = 0;
        for (int c = 0; c < 40 && nGrant < 4; c++) begin
            sample();
            if (req_ready != 2'b00) begin
                grants[nGrant] = req_ready;
                nGrant++;
            end
            tick();
        end
        req_valid = '0;
        checkOutput("rr.count", nGrant, 4);
        for (int i = 0; i < nGrant; i++) begin
            checkOutput($sformatf("rr.grant%0d", i), grants[i], expGrants[i]);
        end
        tick();
        tick();
        sample();
        checkOutput("rr.idle", busy, 1'b0);

        // Stuck waitrequest: counter reaches 4, then the bus drops on the following edge.
        tick();
        driveReq(0, 32'h0000_7000, 1'b0, 2'b10, 1'b0, 32'h0);
        waitrequest = 1'b1;
        sample();
        checkOutput("timeout.ready", req_ready, 2'b01);
        tick();
        req_valid[0] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            sample();
            if (!read) break;
            cnt++;
            tick();
        end
        checkOutput("timeout.read_cycles", cnt, 5);
        checkOutput("timeout.rsp_valid", rsp_valid, 2'b01);
        checkOutput("timeout.rsp_err", rsp_err, 1'b1);
        checkOutput("timeout.rsp_rdata", rsp_rdata, 32'h0);
        waitrequest = 1'b0;
        tick();
        sample();
        checkOutput("timeout.idle", busy, 1'b0);

        // Reset in the middle of a stalled read aborts it with no response.
        tick();
        driveReq(1, 32'h0000_9000, 1'b0, 2'b10, 1'b0, 32'h0);
        waitrequest = 1'b1;
        sample();
        checkOutput("abort.ready", req_ready, 2'b10);
        tick();
        req_valid[1] = 1'b0;
        sample();
        checkOutput("abort.read_before", read, 1'b1);
        tick();
        reset = 1'b1;
        driveReq(0, 32'h0000_0040, 1'b0, 2'b10, 1'b0, 32'h0);
        sample();
        checkOutput("abort.ready_in_reset", req_ready, 2'b00);
        tick();
        reset        = 1'b0;
        req_valid[0] = 1'b0;
        sample();
        checkOutput("abort.read_dropped", read, 1'b0);
        checkOutput("abort.busy", busy, 1'b0);
        checkOutput("abort.no_rsp", rsp_valid, 2'b00);
        for (int c = 0; c < 3; c++) begin
            tick();
            sample();
            checkOutput("abort.still_no_rsp", rsp_valid, 2'b00);
        end
        waitrequest = 1'b0;
        applyStimulus(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global watchdog so a stuck run still terminates.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mips_bus_lsu.md
MIPS_BUS_LSU -- requirements
Module: mips_bus_lsu

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- NPORT, 2, number of requester ports (1-4); port 0 = instruction fetch, port 1 = data.
- ARB_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.
- TIMEOUT, 256, waitrequest stall limit in cycles; 0 disables.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, reset.
- req_valid, in, NPORT, request present per port.
- req_ready, out, NPORT, request accepted this cycle.
- req_addr, in, NPORT*32, byte address per port.
- req_write, in, NPORT, 1 = store, 0 = load.
- req_size, in, NPORT*2, access size.
- req_signed, in, NPORT, sign-extend loads.
- req_wdata, in, NPORT*32, store data, right-justified.
- rsp_valid, out, NPORT, one-cycle response strobe.
- rsp_rdata, out, 32, load result for the strobed port.
- rsp_err, out, 1, misalignment, reserved size or timeout.
- busy, out, 1, high whenever not IDLE.
- address, out, 32, Avalon word address.
- read, out, 1, Avalon read.
- write, out, 1, Avalon write.
- waitrequest, in, 1, Avalon stall.
- writedata, out, 32, Avalon write data.
- byteenable, out, 4, Avalon byte lanes.
- readdata, in, 32, Avalon read data.

REQ-003 reset is reset, synchronous, active-high; clock is clk.

Function
REQ-004 FSM states: IDLE, ISSUE, RESP. Transitions:
- IDLE -> ISSUE on accepting a legal request.
- IDLE -> RESP on accepting an illegal request.
- ISSUE -> RESP when waitrequest is low or the timeout fires.
- RESP -> IDLE unconditionally.

REQ-005 In IDLE, req_ready is combinational: one-hot on the granted port, only when that port's req_valid = 1; zero in every other state.
REQ-006 Arbitration:
- ARB_MODE 0: highest-index valid port wins.
- ARB_MODE 1: search starts at last-granted + 1, wrapping NPORT-1 -> 0.
REQ-007 On acceptance, the module registers the port index, addr, write, size, signed and wdata; requesters hold their inputs stable until ready.
REQ-008 Size encoding: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-009 A request is illegal if any of these hold:
- size = 11;
- half with addr[0] = 1;
- word with addr[1:0] != 0.
An illegal request produces no bus cycle; it gives rsp_valid with rsp_err = 1 and rsp_rdata = 0 one cycle after acceptance.
REQ-010 In ISSUE, bus outputs are driven as follows:
- address = {addr[31:2], 2'b00};
- read = ~write_r, write = write_r;
- byteenable: byte = 4'b0001 << addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111;
- writedata: byte replicated x4, half replicated x2, word as-is.
REQ-011 All bus outputs hold constant while waitrequest = 1; read, write and byteenable are 0 outside ISSUE.
REQ-012 The transfer completes on the first ISSUE edge with waitrequest = 0; readdata is sampled on that same edge.
REQ-013 Load extraction selects the lane by addr[1:0] for bytes and addr[1] for halves; it sign-extends if signed = 1, else zero-extends. Stores return rsp_rdata = 0.
REQ-014 Stall counter:
- cleared on entering ISSUE;
- increments each ISSUE cycle with waitrequest = 1;
- when it equals TIMEOUT (TIMEOUT != 0), read/write drop on the next edge, the FSM goes to RESP, and rsp_err = 1.
REQ-015 In RESP, rsp_valid is high for exactly one cycle on the captured port index; rsp_rdata and rsp_err are valid only then.
REQ-016 Minimum latency, acceptance edge to rsp_valid: 2 cycles (zero-wait bus); 1 cycle for illegal requests. Throughput is at most one request per 3 cycles.
REQ-017 Requests arriving in ISSUE or RESP wait in place; no request is lost or reordered within a port.

Reset
REQ-018 Reset to IDLE; all of these are 0: rsp_valid, rsp_rdata, rsp_err, busy, read, write, byteenable, address, writedata, stall counter; last-granted = NPORT-1.
REQ-019 Reset in ISSUE or RESP aborts immediately: the bus drops on the next edge and no response is issued.
REQ-020 req_ready = 0 while reset = 1.

Structure
REQ-021 Package mips_bus_pkg holds the size enum, the FSM state enum and the byte-lane/extension helper functions.
REQ-022 Sub-module mips_bus_arbiter (NPORT, ARB_MODE) holds the grant and last-granted logic.

Verification
REQ-023 Port 1 loads byte, signed=1, addr 0x1003, readdata 0x80FF_FF00, zero wait -> byteenable 1000, address 0x1000, rsp_rdata 0xFFFF_FF80 two cycles after accept.
REQ-024 Port 1 stores half 0xBEEF at 0x2002, waitrequest high for 3 cycles -> writedata 0xBEEF_BEEF, byteenable 1100, held for 4 cycles, then one rsp_valid with rsp_err = 0.
REQ-025 Word load at 0x3001 -> no read asserted; rsp_valid with rsp_err = 1 one cycle after accept.
REQ-026 ARB_MODE 1, both ports valid continuously -> grants alternate 0, 1, 0, 1.
REQ-027 TIMEOUT = 4, waitrequest stuck high -> read drops after 4 stall cycles, rsp_err = 1.
REQ-028 Reset asserted mid-ISSUE -> read = 0 next edge, no rsp_valid; the next request completes normally.
